// File: rtl/ball_motion.sv
// Pong ball position/direction engine: serve delay, paddle/wall reflection, goals.
// Optional macro SPEEDUP_EN adds a per-rally x-speed register capped at MAX_SPEED.
module ball_motion #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int SPEED_X     = 2,
    parameter int SPEED_Y     = 2,
    parameter int PADDLE_ZONE = 24,
    parameter int WALL_ZONE   = 8,
    parameter int SERVE_DELAY = 60,
    parameter int MAX_SPEED   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic       pause,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       serving,
    output logic       score_p1,
    output logic       score_p2
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] X_CTR = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CTR = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PZ_L  = 10'(PADDLE_ZONE);
    localparam logic [9:0] PZ_R  = 10'(H_ACTIVE - PADDLE_ZONE - BALL_SIZE);
    localparam logic [9:0] WZ_T  = 10'(WALL_ZONE);
    localparam logic [9:0] WZ_B  = 10'(V_ACTIVE - WALL_ZONE - BALL_SIZE);
    localparam int CW = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_DELAY);
    // Step width covers the largest x step the ball can ever take
    localparam int SMAX = (MAX_SPEED > SPEED_X) ? MAX_SPEED : SPEED_X;
    localparam int SW = $clog2(SMAX + 1);

    typedef enum logic [1:0] {SERVE, PLAY, SCORE} state_t;

    state_t state, state_n;
    logic [9:0] x_n, y_n;
    logic dx_n, dy_n;
    logic [CW-1:0] cnt, cnt_n;
    logic srv_dir, srv_dir_n;
    logic winner, winner_n;
    logic [SW-1:0] step;
    logic adv, hit_l, hit_r, hit_t, hit_b;
    logic signed [11:0] nx, ny, sx, sy;
`ifdef SPEEDUP_EN
    logic [SW-1:0] speed, speed_n;
`endif

    assign adv = frame_tick && !pause;

    always_comb begin
        state_n   = state;
        x_n       = ball_x;
        y_n       = ball_y;
        dx_n      = dir_x;
        dy_n      = dir_y;
        cnt_n     = cnt;
        srv_dir_n = srv_dir;
        winner_n  = winner;
`ifdef SPEEDUP_EN
        speed_n   = speed;
        step      = speed;
`else
        step      = SW'(SPEED_X);
`endif
        hit_l = collision && (ball_x < PZ_L) && !dir_x;
        hit_r = collision && (ball_x > PZ_R) && dir_x;
        hit_t = collision && (ball_y < WZ_T) && !dir_y;
        hit_b = collision && (ball_y > WZ_B) && dir_y;
        nx = '0;
        ny = '0;
        sx = '0;
        sy = '0;
        unique case (state)
            SERVE: begin
                if (adv) begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_n = PLAY;
                        dx_n    = srv_dir;
                    end
                end
            end
            PLAY: begin
                if (adv) begin
                    if (hit_l || hit_r) begin
                        dx_n = hit_l;
`ifdef SPEEDUP_EN
                        if (speed < SW'(MAX_SPEED))
                            speed_n = speed + SW'(1);
                        step = speed_n;
`endif
                    end
                    if (hit_t)
                        dy_n = 1'b1;
                    else if (hit_b)
                        dy_n = 1'b0;
                    sx = 12'(step);
                    sy = 12'(SPEED_Y);
                    nx = dx_n ? $signed({2'b00, ball_x}) + sx
                              : $signed({2'b00, ball_x}) - sx;
                    ny = dy_n ? $signed({2'b00, ball_y}) + sy
                              : $signed({2'b00, ball_y}) - sy;
                    // Touching an edge counts as clamping there
                    if (ny <= 12'sd0) begin
                        y_n  = '0;
                        dy_n = 1'b1;
                    end else if (ny >= $signed({2'b00, Y_MAX})) begin
                        y_n  = Y_MAX;
                        dy_n = 1'b0;
                    end else begin
                        y_n = ny[9:0];
                    end
                    if (nx <= 12'sd0) begin
                        x_n      = '0;
                        winner_n = 1'b0;
                        state_n  = SCORE;
                    end else if (nx >= $signed({2'b00, X_MAX})) begin
                        x_n      = X_MAX;
                        winner_n = 1'b1;
                        state_n  = SCORE;
                    end else begin
                        x_n = nx[9:0];
                    end
                end
            end
            SCORE: begin
                state_n   = SERVE;
                x_n       = X_CTR;
                y_n       = Y_CTR;
                cnt_n     = CNT_INIT;
                srv_dir_n = winner;
`ifdef SPEEDUP_EN
                speed_n   = SW'(SPEED_X);
`endif
            end
            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SERVE;
            ball_x  <= X_CTR;
            ball_y  <= Y_CTR;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
            cnt     <= CNT_INIT;
            srv_dir <= 1'b1;
            winner  <= 1'b0;
`ifdef SPEEDUP_EN
            speed   <= SW'(SPEED_X);
`endif
        end else begin
            state   <= state_n;
            ball_x  <= x_n;
            ball_y  <= y_n;
            dir_x   <= dx_n;
            dir_y   <= dy_n;
            cnt     <= cnt_n;
            srv_dir <= srv_dir_n;
            winner  <= winner_n;
`ifdef SPEEDUP_EN
            speed   <= speed_n;
`endif
        end
    end

    assign serving  = (state == SERVE);
    assign score_p1 = (state == SCORE) && winner;
    assign score_p2 = (state == SCORE) && !winner;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: scripted vector table, goal sequence,
// and random play against a frame-level reference model.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst, frame_tick, collision, pause;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, serving, score_p1, score_p2;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .collision(collision), .pause(pause),
        .ball_x(ball_x), .ball_y(ball_y),
        .dir_x(dir_x), .dir_y(dir_y), .serving(serving),
        .score_p1(score_p1), .score_p2(score_p2)
    );

    int errors = 0;
    int checks = 0;
    logic sc1, sc2;

    typedef struct {
        bit rs; int n; bit c; bit p;
        int ex; int ey; bit edx; bit edy; bit esrv;
    } vec_t;
    vec_t tv[17];

    // Reference model state
    int m_x, m_y, m_cnt, m_spd;
    bit m_dx, m_dy, m_srv, m_sdir, g1, g2;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b0;
        collision = 1'b0;
        pause = 1'b0;
        #2;
        chk("async_rst_serving", serving, 1);
        chk("async_rst_x", ball_x, 316);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick(input bit c, input bit p);
        @(negedge clk);
        frame_tick = 1'b1;
        collision = c;
        pause = p;
        @(negedge clk);
        frame_tick = 1'b0;
        collision = 1'b0;
        pause = 1'b0;
        sc1 = score_p1;
        sc2 = score_p2;
        @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        if (tv[i].rs) do_reset();
        repeat (tv[i].n) tick(tv[i].c, tv[i].p);
        chk($sformatf("v%0d_x", i), ball_x, tv[i].ex);
        chk($sformatf("v%0d_y", i), ball_y, tv[i].ey);
        chk($sformatf("v%0d_dx", i), dir_x, tv[i].edx);
        chk($sformatf("v%0d_dy", i), dir_y, tv[i].edy);
        chk($sformatf("v%0d_srv", i), serving, tv[i].esrv);
    endtask

    task automatic model_init();
        m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
        m_srv = 1; m_cnt = 60; m_sdir = 1; m_spd = 2;
    endtask

    // One frame of game rules, with the one-cycle score phase folded in
    task automatic model_tick(input bit c, input bit p);
        bit hx, hy;
        g1 = 0;
        g2 = 0;
        if (p) return;
        if (m_srv) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_srv = 0;
                m_dx = m_sdir;
            end
            return;
        end
        hx = c && ((m_x < 24 && !m_dx) || (m_x > 608 && m_dx));
        hy = c && ((m_y < 8 && !m_dy) || (m_y > 464 && m_dy));
        if (hx) begin
            m_dx = !m_dx;
`ifdef SPEEDUP_EN
            if (m_spd < 5) m_spd++;
`endif
        end
        if (hy) m_dy = !m_dy;
        m_x = m_dx ? m_x + m_spd : m_x - m_spd;
        m_y = m_dy ? m_y + 2 : m_y - 2;
        if (m_y <= 0) begin m_y = 0; m_dy = 1; end
        else if (m_y >= 472) begin m_y = 472; m_dy = 0; end
        if (m_x <= 0) g2 = 1;
        else if (m_x >= 632) g1 = 1;
        if (g1 || g2) begin
            m_x = 316; m_y = 236; m_srv = 1; m_cnt = 60;
            m_sdir = g1; m_spd = 2;
        end
    endtask

    initial begin
        bit c, p;
        rst = 1'b1;
        frame_tick = 1'b0;
        collision = 1'b0;
        pause = 1'b0;
        sc1 = 1'b0;
        sc2 = 1'b0;
`ifndef SPEEDUP_EN
        tv[0]  = '{1,   0, 0, 0, 316, 236, 1, 1, 1};
        tv[1]  = '{0,  59, 0, 0, 316, 236, 1, 1, 1};
        tv[2]  = '{0,   1, 0, 0, 316, 236, 1, 1, 0};
        tv[3]  = '{0,   1, 0, 0, 318, 238, 1, 1, 0};
        tv[4]  = '{0,  10, 1, 1, 318, 238, 1, 1, 0};
        tv[5]  = '{0,   1, 1, 0, 320, 240, 1, 1, 0};
        tv[6]  = '{0, 146, 0, 0, 612, 412, 1, 0, 0};
        tv[7]  = '{0,   1, 1, 0, 610, 410, 0, 0, 0};
        tv[8]  = '{0, 203, 0, 0, 204,   4, 0, 0, 0};
        tv[9]  = '{0,   1, 1, 0, 202,   6, 0, 1, 0};
        tv[10] = '{0, 100, 0, 0,   2, 206, 0, 1, 0};
        tv[11] = '{0,  59, 0, 0, 316, 236, 0, 1, 1};
        tv[12] = '{0,   1, 0, 0, 316, 236, 0, 1, 0};
        tv[13] = '{0,   1, 0, 0, 314, 238, 0, 1, 0};
        tv[14] = '{1,   0, 0, 0, 316, 236, 1, 1, 1};
        tv[15] = '{0,  60, 0, 0, 316, 236, 1, 1, 0};
        tv[16] = '{0, 149, 0, 0, 614, 410, 1, 0, 0};
        for (int i = 0; i <= 10; i++) run_vec(i);
        // Left goal, with a frame tick landing on the score cycle
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        chk("goal_p2", score_p2, 1);
        chk("goal_p1", score_p1, 0);
        chk("goal_x", ball_x, 0);
        @(negedge clk);
        frame_tick = 1'b0;
        chk("post_p2", score_p2, 0);
        chk("post_srv", serving, 1);
        chk("post_x", ball_x, 316);
        chk("post_y", ball_y, 236);
        for (int i = 11; i <= 16; i++) run_vec(i);
`endif
        do_reset();
        model_init();
        for (int k = 0; k < 4000; k++) begin
            c = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 9) == 0);
            model_tick(c, p);
            tick(c, p);
            chk("rnd_p1", sc1, g1);
            chk("rnd_p2", sc2, g2);
            chk("rnd_x", ball_x, m_x);
            chk("rnd_y", ball_y, m_y);
            chk("rnd_dx", dir_x, m_dx);
            chk("rnd_dy", dir_y, m_dy);
            chk("rnd_srv", serving, m_srv);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
Per-frame ball position/direction engine for Pong, directly downstream of the collision detector. Once per frame it samples the frame-latched collision flag, classifies the hit by ball position (paddle zone or wall zone), reflects direction, advances the ball, and detects goals. Outputs ball_x/ball_y feed the ball pixel generator, and score pulses feed the scoreboard.

Parameters:
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in lines
BALL_SIZE, 8, ball edge length in pixels
SPEED_X, 2, horizontal step per frame (pixels)
SPEED_Y, 2, vertical step per frame (lines)
PADDLE_ZONE, 24, x band at each side where a collision counts as a paddle hit
WALL_ZONE, 8, y band at top/bottom where a collision counts as a wall hit
SERVE_DELAY, 60, frames the ball rests at centre before a serve
MAX_SPEED, 5, x-speed ceiling (SPEEDUP_EN only)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-clk pulse, synchronous to clk, asserted once per frame at the vsync falling edge
collision  in  1  level from the collision detector; sampled only on frame_tick
pause  in  1  high freezes all state; frame_tick is ignored
ball_x  out  10  ball left edge, 0..H_ACTIVE-BALL_SIZE
ball_y  out  10  ball top edge, 0..V_ACTIVE-BALL_SIZE
dir_x  out  1  1 = moving right
dir_y  out  1  1 = moving down
serving  out  1  high in SERVE state
score_p1  out  1  one-clk pulse: player 1 (left) scores
score_p2  out  1  one-clk pulse: player 2 (right) scores

Behaviour:
- Reset, asynchronous: ball_x=(H_ACTIVE-BALL_SIZE)/2 (316), ball_y=(V_ACTIVE-BALL_SIZE)/2 (236), dir_x=1, dir_y=1, serving=1, score pulses=0, state=SERVE, serve counter=SERVE_DELAY, next serve direction=right. A reset mid-frame or mid-SCORE returns to this state immediately.
- All updates occur only on a clk edge where frame_tick=1 and pause=0. Outputs change the cycle after that edge. Between ticks all outputs hold.
- SERVE: each tick decrements the counter. On the tick where the counter reaches 0, enter PLAY, set serving=0, and load dir_x from the serve direction. The ball does not move on that tick.
- PLAY, on each tick:
  1. Reflect, only if collision=1:
     - ball_x<PADDLE_ZONE and dir_x=0: dir_x<=1.
     - ball_x>H_ACTIVE-PADDLE_ZONE-BALL_SIZE and dir_x=1: dir_x<=0.
     - ball_y<WALL_ZONE and dir_y=0: dir_y<=1.
     - ball_y>V_ACTIVE-WALL_ZONE-BALL_SIZE and dir_y=1: dir_y<=0.
     - X and Y reflections are independent. A corner hit flips both.
     - A collision outside all zones is ignored.
  2. Move using the updated directions. Use wider intermediate arithmetic and clamp to [0, max] with no wraparound.
  3. If y clamps at 0 or at the maximum, force dir_y to point away from that edge (safety bounce, no collision required).
  4. If x clamps at 0, go to SCORE with winner p2. If x clamps at the maximum, go to SCORE with winner p1.
- SCORE: lasts one clk cycle (not one frame).
  - Pulse score_p1 or score_p2 for exactly 1 cycle.
  - Centre the ball, set serving=1, reload the counter to SERVE_DELAY, and go to SERVE.
  - Set the next serve direction toward the player who conceded. dir_y is kept.
- pause=1 during SERVE: the counter is frozen.
- A frame_tick that coincides with SCORE is ignored.

Optional Feature:
SPEEDUP_EN
- Defined: a register cur_speed_x replaces SPEED_X. It increments by 1 on each paddle reflection, saturating at MAX_SPEED. It reloads to SPEED_X on reset and on entry to SERVE.
- Undefined: the x step is the constant SPEED_X. There is no speed register and MAX_SPEED is unused.

Test Plan:
- Serve: release rst, issue 60 frame_ticks with collision=0. serving drops after tick 60 with ball at (316,236). Tick 61 gives ball (318,238), dir_x=1, dir_y=1.
- Right paddle: ball_x=612, dir_x=1, collision=1 on a tick -> dir_x=0, ball_x=610. The same case with collision=0 -> ball_x=614, no flip.
- Top wall: ball_y=4, dir_y=0, collision=1 -> dir_y=1, ball_y=6. Ball_y=1, dir_y=0, no collision -> ball_y=0 and dir_y=1 (safety bounce).
- Goal: ball_x=1, dir_x=0, collision=0, tick -> score_p2 high for exactly 1 clk. Ball returns to (316,236) with serving=1, and the next serve has dir_x=0 after 60 ticks.
- Pause/ignore: pause=1 with 10 ticks -> outputs unchanged. pause=0 with ball at (300,200), collision=1 -> no reflection, normal move.
- SPEEDUP_EN: four consecutive paddle hits -> x step 3,4,5,5. After a goal and serve, x step returns to 2.
